// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, vector-stall FSM states
// and the vector-occupancy counter width helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        VEC_WAIT = 1'b1
    } vec_state_t;

    // Counter width for a VEC_LAT-cycle vector op, never narrower than one bit
    function automatic int unsigned vec_cnt_w(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/forward_select.sv
// Operand forwarding select for one E-stage source register; M has priority over W.
module forward_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic [REG_AW-1:0] i_ra_e,
    input  logic [REG_AW-1:0] i_wa_m,
    input  logic [REG_AW-1:0] i_wa_w,
    input  logic              i_we_m,
    input  logic              i_we_w,
    output fwd_sel_t          o_sel_c
);

    always_comb begin
        o_sel_c = FWD_RF;
        if (i_we_m && (i_wa_m == i_ra_e)) begin
            o_sel_c = FWD_M;
        end else if (i_we_w && (i_wa_w == i_ra_e)) begin
            o_sel_c = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: forwarding, load-use stall, branch flush and a
// counter FSM freezing the pipe during multi-cycle vector memory ops. Define HAZARD_PERF_EN for perf counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned VEC_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] RA1E,
    input  logic [REG_AW-1:0] RA2E,
    input  logic [REG_AW-1:0] WA3E,
    input  logic [REG_AW-1:0] WA3M,
    input  logic [REG_AW-1:0] WA3W,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              BranchTakenE,
    input  logic              VecMemM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              VecBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       PerfStallCnt,
    output logic [31:0]       PerfFlushCnt
`endif
);

    localparam int unsigned CNT_W = vec_cnt_w(VEC_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((VEC_LAT > 1) ? (VEC_LAT - 2) : 0);

    fwd_sel_t          w_fwd_a;
    fwd_sel_t          w_fwd_b;
    vec_state_t        r_state;
    vec_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_vec_busy;
    logic              w_vstall;
    logic              w_ldstall;

    forward_select #(.REG_AW(REG_AW)) u_fwd_a (
        .i_ra_e  (RA1E),
        .i_wa_m  (WA3M),
        .i_wa_w  (WA3W),
        .i_we_m  (RegWriteM),
        .i_we_w  (RegWriteW),
        .o_sel_c (w_fwd_a)
    );

    forward_select #(.REG_AW(REG_AW)) u_fwd_b (
        .i_ra_e  (RA2E),
        .i_wa_m  (WA3M),
        .i_wa_w  (WA3W),
        .i_we_m  (RegWriteM),
        .i_we_w  (RegWriteW),
        .o_sel_c (w_fwd_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_vec_busy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_vec_busy <= (w_state_nxt == VEC_WAIT);
        end
    end

    // The cycle the op leaves M (cnt==0) is not stalled, so the op occupies M for VEC_LAT cycles
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_vstall    = 1'b0;
        case (r_state)
            IDLE: begin
                if (VecMemM && (VEC_LAT > 1)) begin
                    w_vstall    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = VEC_WAIT;
                end
            end
            VEC_WAIT: begin
                if (r_cnt != '0) begin
                    w_vstall  = 1'b1;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_ldstall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));

    // Everything is forced quiet while reset is held
    assign ForwardAE = rst ? w_fwd_a : FWD_RF;
    assign ForwardBE = rst ? w_fwd_b : FWD_RF;
    assign StallF    = rst && (w_vstall || w_ldstall);
    assign StallD    = rst && (w_vstall || w_ldstall);
    assign StallE    = rst && w_vstall;
    assign StallM    = rst && w_vstall;
    assign FlushW    = rst && w_vstall;
    assign FlushD    = rst && !w_vstall && BranchTakenE;
    assign FlushE    = rst && !w_vstall && (BranchTakenE || w_ldstall);
    assign VecBusy   = r_vec_busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (StallF) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (FlushD || FlushE) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign PerfStallCnt = r_perf_stall;
    assign PerfFlushCnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus randomized traffic
// against an occupancy-based reference model.
module tb_hazard_controller;

    localparam int unsigned REG_AW  = 4;
    localparam int unsigned VEC_LAT = 4;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic              RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, VecMemM;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, VecBusy;
`ifdef HAZARD_PERF_EN
    logic [31:0]       PerfStallCnt, PerfFlushCnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: m_k = cycles the current vector op has already spent in M (0 = none)
    int          m_k = 0;
    logic [31:0] m_perf_stall = '0;
    logic [31:0] m_perf_flush = '0;

    logic [6:0] obs_sf;
    assign obs_sf = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    hazard_controller #(.REG_AW(REG_AW), .VEC_LAT(VEC_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .BranchTakenE (BranchTakenE),
        .VecMemM      (VecMemM),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .VecBusy      (VecBusy)
`ifdef HAZARD_PERF_EN
        ,
        .PerfStallCnt (PerfStallCnt),
        .PerfFlushCnt (PerfFlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index of the vector op in M this cycle, counting a newly arriving op
    function automatic int eff_k();
        return (m_k == 0 && VecMemM) ? 1 : m_k;
    endfunction

    // Expected {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    function automatic logic [6:0] exp_sf();
        int   ek = eff_k();
        logic v;
        logic ld;
        if (!rst) return 7'b0;
        v  = (ek != 0) && (ek < int'(VEC_LAT));
        ld = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
        if (v) return 7'b1111001;
        return {ld, ld, 1'b0, 1'b0, BranchTakenE, BranchTakenE | ld, 1'b0};
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [REG_AW-1:0] ra);
        if (!rst) return 2'b00;
        if (RegWriteM && WA3M == ra) return 2'b10;
        if (RegWriteW && WA3W == ra) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_busy();
        return rst && (m_k >= 2);
    endfunction

    // Advance one clock and the model with it; returns just after the falling edge
    task automatic tick();
        int         ek = eff_k();
        logic [6:0] sf = exp_sf();
        @(posedge clk);
        if (rst) begin
            m_perf_stall = m_perf_stall + 32'(sf[6]);
            m_perf_flush = m_perf_flush + 32'(sf[2] | sf[1]);
            m_k = (ek == 0 || ek == int'(VEC_LAT)) ? 0 : ek + 1;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        RA1D = '0; RA2D = 4'd1; RA1E = '0; RA2E = '0;
        WA3E = 4'd15; WA3M = '0; WA3W = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        BranchTakenE = 1'b0; VecMemM = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2 rst = 1'b0;
        MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2; BranchTakenE = 1'b1; VecMemM = 1'b1;
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; RA2E = 4'd4; WA3W = 4'd4; RegWriteW = 1'b1;
        #1;
        checks++;
        if (obs_sf !== 7'b0) begin
            failures++; $display("FAIL reset_stall_flush: got %b expected 0000000", obs_sf);
        end
        checks++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
            failures++; $display("FAIL reset_forward: got A=%b B=%b expected 00/00", ForwardAE, ForwardBE);
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if (VecBusy !== 1'b0) begin
            failures++; $display("FAIL reset_vecbusy: got %b expected 0", VecBusy);
        end
        clear_inputs();
        rst = 1'b1;
        m_k = 0; m_perf_stall = '0; m_perf_flush = '0;
    endtask

    task automatic test_forwarding();
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1; RA2E = 4'd5;
        #1;
        checks++;
        if (ForwardAE !== 2'b10) begin
            failures++; $display("FAIL fwd_m_priority: got %b expected 10", ForwardAE);
        end
        checks++;
        if (ForwardBE !== 2'b00) begin
            failures++; $display("FAIL fwd_b_nomatch: got %b expected 00", ForwardBE);
        end
        RegWriteM = 1'b0;
        #1;
        checks++;
        if (ForwardAE !== 2'b01) begin
            failures++; $display("FAIL fwd_w: got %b expected 01", ForwardAE);
        end
        RA2E = 4'd15; WA3W = 4'd15; RA1E = 4'd0;
        #1;
        checks++;
        if (ForwardBE !== 2'b01 || ForwardAE !== 2'b00) begin
            failures++; $display("FAIL fwd_reg15: got A=%b B=%b expected 00/01", ForwardAE, ForwardBE);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        MemtoRegE = 1'b1; WA3E = 4'd2; RA1D = 4'd2; RA2D = 4'd7;
        #1;
        checks++;
        if (obs_sf !== 7'b1100010) begin
            failures++; $display("FAIL load_use_ra1: got %b expected 1100010", obs_sf);
        end
        tick();
        MemtoRegE = 1'b0;
        #1;
        checks++;
        if (obs_sf !== 7'b0) begin
            failures++; $display("FAIL load_use_release: got %b expected 0000000", obs_sf);
        end
        MemtoRegE = 1'b1; RA1D = 4'd9; RA2D = 4'd2;
        #1;
        checks++;
        if (obs_sf !== 7'b1100010) begin
            failures++; $display("FAIL load_use_ra2: got %b expected 1100010", obs_sf);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch();
        BranchTakenE = 1'b1;
        #1;
        checks++;
        if (obs_sf !== 7'b0000110) begin
            failures++; $display("FAIL branch_flush: got %b expected 0000110", obs_sf);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_vector_op();
        VecMemM = 1'b1; BranchTakenE = 1'b1;
        RA1E = 4'd4; WA3M = 4'd4; RegWriteM = 1'b1;
        for (int c = 1; c <= int'(VEC_LAT); c++) begin
            logic [6:0] want;
            want = (c < int'(VEC_LAT)) ? 7'b1111001 : 7'b0000110;
            #1;
            checks++;
            if (obs_sf !== want) begin
                failures++; $display("FAIL vec_cycle%0d: got %b expected %b", c, obs_sf, want);
            end
            checks++;
            if (ForwardAE !== 2'b10) begin
                failures++; $display("FAIL vec_fwd_cycle%0d: got %b expected 10", c, ForwardAE);
            end
            if (c < int'(VEC_LAT)) begin
                checks++;
                if (VecBusy !== (c >= 2)) begin
                    failures++; $display("FAIL vec_busy_cycle%0d: got %b expected %b", c, VecBusy, c >= 2);
                end
            end
            tick();
            if (c == int'(VEC_LAT) - 1) VecMemM = 1'b1;
        end
        clear_inputs();
        #1;
        checks++;
        if (obs_sf !== 7'b0 || VecBusy !== 1'b0) begin
            failures++; $display("FAIL vec_done: got sf=%b busy=%b expected 0000000/0", obs_sf, VecBusy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        VecMemM = 1'b1;
        for (int c = 1; c <= 2 * int'(VEC_LAT); c++) begin
            logic [6:0] want;
            want = ((c % int'(VEC_LAT)) != 0) ? 7'b1111001 : 7'b0000000;
            #1;
            checks++;
            if (obs_sf !== want) begin
                failures++; $display("FAIL b2b_cycle%0d: got %b expected %b", c, obs_sf, want);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_op();
        VecMemM = 1'b1;
        tick();
        #1;
        checks++;
        if (VecBusy !== 1'b1) begin
            failures++; $display("FAIL midop_busy: got %b expected 1", VecBusy);
        end
        RA1E = 4'd6; WA3M = 4'd6; RegWriteM = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (obs_sf !== 7'b0 || VecBusy !== 1'b0 || ForwardAE !== 2'b00) begin
            failures++; $display("FAIL midop_async_reset: got sf=%b busy=%b fa=%b expected 0000000/0/00",
                                 obs_sf, VecBusy, ForwardAE);
        end
        @(posedge clk); @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        m_k = 0; m_perf_stall = '0; m_perf_flush = '0;
        #1;
        checks++;
        if (obs_sf !== 7'b0 || VecBusy !== 1'b0) begin
            failures++; $display("FAIL midop_release: got sf=%b busy=%b expected 0000000/0", obs_sf, VecBusy);
        end
        tick();
        #1;
        checks++;
        if (VecBusy !== 1'b0) begin
            failures++; $display("FAIL midop_idle: got %b expected 0", VecBusy);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        BranchTakenE = 1'b1;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (PerfFlushCnt !== 32'd1 || PerfStallCnt !== 32'd0) begin
            failures++; $display("FAIL perf_branch: got stall=%0d flush=%0d expected 0/1", PerfStallCnt, PerfFlushCnt);
        end
        VecMemM = 1'b1;
        for (int c = 0; c < int'(VEC_LAT); c++) tick();
        clear_inputs();
        MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (PerfStallCnt !== 32'd4 || PerfFlushCnt !== 32'd2) begin
            failures++; $display("FAIL perf_stall: got stall=%0d flush=%0d expected 4/2", PerfStallCnt, PerfFlushCnt);
        end
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 500; n++) begin
            RA1D = REG_AW'($urandom_range(0, 3)); RA2D = REG_AW'($urandom_range(0, 3));
            RA1E = REG_AW'($urandom_range(0, 3)); RA2E = REG_AW'($urandom_range(0, 3));
            WA3E = REG_AW'($urandom_range(0, 3)); WA3M = REG_AW'($urandom_range(0, 3));
            WA3W = REG_AW'($urandom_range(0, 3));
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemtoRegE    = ($urandom_range(0, 3) == 0);
            BranchTakenE = ($urandom_range(0, 4) == 0);
            VecMemM      = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (obs_sf !== exp_sf() || ForwardAE !== exp_fwd(RA1E) || ForwardBE !== exp_fwd(RA2E)
                || VecBusy !== exp_busy()) begin
                failures++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d: got sf=%b fa=%b fb=%b busy=%b expected %b/%b/%b/%b",
                             n, obs_sf, ForwardAE, ForwardBE, VecBusy,
                             exp_sf(), exp_fwd(RA1E), exp_fwd(RA2E), exp_busy());
                bad++;
            end
            tick();
        end
        clear_inputs();
`ifdef HAZARD_PERF_EN
        #1;
        checks++;
        if (PerfStallCnt !== m_perf_stall || PerfFlushCnt !== m_perf_flush) begin
            failures++; $display("FAIL random_perf: got stall=%0d flush=%0d expected %0d/%0d",
                                 PerfStallCnt, PerfFlushCnt, m_perf_stall, m_perf_flush);
        end
`endif
    endtask

    initial begin
        test_reset();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        test_forwarding();
        test_load_use();
        test_branch();
        test_vector_op();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline hazard controller for the five-stage (F/D/E/M/W) processor core. It sits beside the execute-stage conditional unit and sequences the pipeline:
- operand forwarding selects for E;
- load-use stall;
- branch flush driven by BranchTakenE from the conditional unit;
- a counter-based FSM that freezes the pipeline while a multi-cycle SIMD vector memory access (AES state load/store) occupies M.

Parameters:
REG_AW, 4, register address width (16 scalar registers)
VEC_LAT, 4, cycles a vector memory op occupies M (>=1); stall cycles = VEC_LAT-1

Ports:
clk  in  1  pipeline clock
rst  in  1  reset, asynchronous, active-low
RA1D  in  REG_AW  source reg 1 of instruction in D
RA2D  in  REG_AW  source reg 2 of instruction in D
RA1E  in  REG_AW  source reg 1 of instruction in E
RA2E  in  REG_AW  source reg 2 of instruction in E
WA3E  in  REG_AW  destination reg in E
WA3M  in  REG_AW  destination reg in M
WA3W  in  REG_AW  destination reg in W
RegWriteM  in  1  M instruction writes register file (post-condition)
RegWriteW  in  1  W instruction writes register file
MemtoRegE  in  1  E instruction is a scalar load
BranchTakenE  in  1  branch resolved taken in E (from conditional unit)
VecMemM  in  1  instruction in M is a vector memory op
ForwardAE  out  2  operand A select: 00 regfile, 01 W result, 10 M ALU result
ForwardBE  out  2  operand B select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
FlushW  out  1  insert bubble into M/W register
VecBusy  out  1  registered, high while FSM in VEC_WAIT

Behaviour:
- Reset (rst low, async):
  - state=IDLE, cnt=0, VecBusy=0.
  - While rst is low, all stall/flush outputs are forced 0 and ForwardAE/BE=00.
- Forwarding (combinational), per operand X in {1,2}:
  - RegWriteM && WA3M==RAXE -> 10;
  - else RegWriteW && WA3W==RAXE -> 01;
  - else 00.
  - M has priority over W. All addresses are forwardable.
  - Forwarding stays active during stalls.
- Load-use (combinational): ldstall = MemtoRegE && (WA3E==RA1D || WA3E==RA2D).
- Normal mode (not vector-stalled):
  - StallF = StallD = ldstall.
  - FlushD = BranchTakenE.
  - FlushE = BranchTakenE || ldstall.
  - StallE = StallM = FlushW = 0.
- Vector stall (vstall=1):
  - StallF = StallD = StallE = StallM = 1, FlushW = 1.
  - FlushD = FlushE = 0.
  - A taken branch or load-use hazard held in E/D is acted on in the first non-stalled cycle.
- FSM states and transitions:
  - IDLE:
    - If VecMemM && VEC_LAT>1: vstall=1, cnt<=VEC_LAT-2, next VEC_WAIT.
    - Otherwise vstall=0.
  - VEC_WAIT:
    - If cnt!=0: vstall=1, cnt<=cnt-1.
    - If cnt==0: vstall=0, next IDLE (the op leaves M this cycle).
  - VecBusy=1 exactly in VEC_WAIT.
- Latency: a vector op stays in M for exactly VEC_LAT cycles.
- Back-to-back vector ops: the second enters M from the IDLE cycle that follows and triggers a fresh sequence.
- Counter width $clog2(VEC_LAT) (minimum 1). No wrap: decrement never occurs at 0.
- VEC_LAT=1: FSM never leaves IDLE, vector ops cost no stalls.
- Reset mid-VEC_WAIT returns to IDLE immediately; the pipeline is reset alongside.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs PerfStallCnt[31:0] and PerfFlushCnt[31:0].
  - PerfStallCnt increments on every cycle with StallF=1.
  - PerfFlushCnt increments on every cycle with FlushD=1 or FlushE=1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
  - vec_state_t enum (IDLE, VEC_WAIT).
- Sub-module forward_select: one per operand. Compares RAXE against WA3M/WA3W and returns fwd_sel_t. Instantiated twice.

Test Plan:
- Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. With RegWriteM=0 -> 01. RA2E=5 with no match -> ForwardBE=00.
- Load-use: MemtoRegE=1, WA3E=2, RA1D=2 -> StallF=StallD=FlushE=1, FlushD=0, for one cycle.
- Branch: BranchTakenE=1, no other hazard -> FlushD=FlushE=1, no stalls.
- Vector op, VEC_LAT=4: VecMemM=1 from IDLE -> StallF..StallM=FlushW=1 for 3 cycles, VecBusy=1 for cycles 2-3, all 0 in cycle 4, then IDLE. BranchTakenE=1 during the stall -> FlushD=FlushE=0 until cycle 4, then 1.
- Reset mid-op: drop rst during VEC_WAIT -> all outputs 0 asynchronously. After release with VecMemM=0 -> IDLE, no stall.
- HAZARD_PERF_EN: 3-cycle vector stall plus 1 load-use stall -> PerfStallCnt=4. One branch -> PerfFlushCnt=1.
